// File: rtl/sum_accumulator.sv
// sum_accumulator: sums N_SAMPLES 5-bit results {cout,sum} from an upstream
// 4-bit adder into an ACC_W-bit frame total with a valid/ready handshake on
// both sides and a sticky overflow flag.
// Build option: define SUM_ACC_SATURATE_EN to clamp the accumulator at
// 2^ACC_W-1 on overflow; otherwise it wraps modulo 2^ACC_W.
module sum_accumulator #(
    parameter int unsigned N_SAMPLES = 4,
    parameter int unsigned ACC_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       sum,
    input  logic             cout,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam logic [7:0]       LAST_CNT = 8'(N_SAMPLES - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [7:0]       count_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             accept;
    logic [ACC_W:0]   add_wide;
    logic             add_ovf;

    // Next accumulator value for an accepted input, with carry-out as overflow.
    always_comb begin
        accept   = in_valid & in_ready_q;
        add_wide = {1'b0, acc_q} + {{(ACC_W - 4){1'b0}}, cout, sum};
        add_ovf  = add_wide[ACC_W];
`ifdef SUM_ACC_SATURATE_EN
        acc_d    = add_ovf ? ACC_MAX : add_wide[ACC_W-1:0];
`else
        acc_d    = add_wide[ACC_W-1:0];
`endif
    end

    // Frame FSM: state, accumulator, sample count, sticky overflow and
    // registered handshake flags all update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q      <= '0;
                        count_q    <= '0;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_q   <= acc_d;
                        count_q <= count_q + 8'd1;
                        if (add_ovf) begin
                            ovf_q <= 1'b1;
                        end
                        if (count_q == LAST_CNT) begin
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Accumulator is kept; it is only cleared by the next start.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = out_valid_q;
        result    = acc_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: an N=4 instance for framing, handshake,
// ignored-event and reset tests, and an N=16 instance for overflow.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] sum = '0;
    logic       cout = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, ovf;
    logic [7:0] result;
    logic       in_ready_b, out_valid_b, ovf_b;
    logic [7:0] result_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] val;
        logic [7:0] exp_acc;
    } vec_t;

    vec_t frame[4];

`ifdef SUM_ACC_SATURATE_EN
    localparam logic [7:0] EXP_B_AFTER9 = 8'd255;
    localparam logic [7:0] EXP_B_FINAL  = 8'd255;
`else
    localparam logic [7:0] EXP_B_AFTER9 = 8'd23;
    localparam logic [7:0] EXP_B_FINAL  = 8'd240;
`endif

    sum_accumulator #(.N_SAMPLES(4), .ACC_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sum(sum), .cout(cout),
        .in_valid(in_valid), .in_ready(in_ready), .result(result),
        .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
    );

    sum_accumulator #(.N_SAMPLES(16), .ACC_W(8)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .sum(sum), .cout(cout),
        .in_valid(in_valid), .in_ready(in_ready_b), .result(result_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pulse reset between clock edges, then realign to just after a rising edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push(input logic [4:0] v);
        {cout, sum} = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Apply the frame table with 'gap' idle cycles before each input;
    // when noise is set, start is pulsed during the gaps.
    task automatic run_frame(input int gap, input bit noise);
        logic [7:0] prev;
        prev = '0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                start = noise;
                {cout, sum} = 5'd17;
                @(posedge clk);
                #1;
                start = 1'b0;
                chk("gap_hold", 32'(result), 32'(prev));
                chk("gap_in_ready", 32'(in_ready), 32'd1);
            end
            push(frame[i].val);
            chk("acc_step", 32'(result), 32'(frame[i].exp_acc));
            chk("ovf_step", 32'(ovf), 32'd0);
            chk("out_valid_step", 32'(out_valid), (i == 3) ? 32'd1 : 32'd0);
            chk("in_ready_step", 32'(in_ready), (i == 3) ? 32'd0 : 32'd1);
            prev = frame[i].exp_acc;
        end
    endtask

    initial begin
        frame[0] = '{val: 5'd3,  exp_acc: 8'd3};
        frame[1] = '{val: 5'd5,  exp_acc: 8'd8};
        frame[2] = '{val: 5'd7,  exp_acc: 8'd15};
        frame[3] = '{val: 5'd31, exp_acc: 8'd46};

        // Reset then idle for 10 cycles.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            chk("idle_outputs", {21'd0, result, out_valid, in_ready, ovf}, 32'd0);
            @(posedge clk);
            #1;
        end

        // Basic back-to-back frame.
        pulse_start();
        chk("start_in_ready", 32'(in_ready), 32'd1);
        run_frame(0, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hs_out_valid", 32'(out_valid), 32'd0);
        chk("hs_in_ready", 32'(in_ready), 32'd0);
        chk("hs_result_kept", 32'(result), 32'd46);

        // Gaps, backpressure and ignored events.
        do_reset();
        {cout, sum} = 5'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("idle_in_valid_ignored", 32'(result), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        pulse_start();
        run_frame(2, 1'b1);
        for (int c = 0; c < 5; c++) begin
            start = c[0];
            in_valid = 1'b1;
            {cout, sum} = 5'd4;
            @(posedge clk);
            #1;
            chk("done_result_held", 32'(result), 32'd46);
            chk("done_out_valid", 32'(out_valid), 32'd1);
            chk("done_in_ready", 32'(in_ready), 32'd0);
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_result", 32'(result), 32'd46);

        // Overflow on the 16-sample instance; the 4-sample one finishes early.
        do_reset();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            push(5'd31);
            if (i == 7) begin
                chk("ovf_pre_result", 32'(result_b), 32'd248);
                chk("ovf_pre_flag", 32'(ovf_b), 32'd0);
            end
            if (i == 8) begin
                chk("ovf_first_result", 32'(result_b), 32'(EXP_B_AFTER9));
                chk("ovf_first_flag", 32'(ovf_b), 32'd1);
            end
        end
        chk("ovf_final_result", 32'(result_b), 32'(EXP_B_FINAL));
        chk("ovf_final_flag", 32'(ovf_b), 32'd1);
        chk("ovf_final_valid", 32'(out_valid_b), 32'd1);
        chk("n4_result", 32'(result), 32'd124);
        chk("n4_ovf", 32'(ovf), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("ovf_hs_valid", 32'(out_valid_b), 32'd0);
        chk("ovf_sticky_after_hs", 32'(ovf_b), 32'd1);
        pulse_start();
        chk("restart_clears_ovf", 32'(ovf_b), 32'd0);
        chk("restart_clears_acc", 32'(result_b), 32'd0);

        // Reset mid-frame.
        do_reset();
        pulse_start();
        push(5'd10);
        push(5'd10);
        chk("mid_acc", 32'(result), 32'd20);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", {21'd0, result, out_valid, in_ready, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push(5'd1);
        chk("post_rst_no_start", 32'(result), 32'd0);
        pulse_start();
        for (int i = 0; i < 4; i++) push(5'd1);
        chk("post_rst_frame", 32'(result), 32'd4);
        chk("post_rst_valid", 32'(out_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
